// File: rtl/mem_acc_cont_sram_bank_pkg.sv
// Shared constants and helpers for the memory access controller SRAM bank.
// Defaults match the standard bank: 64-bit words, 4096 entries, latency 1.
package mem_acc_cont_sram_bank_pkg;

    localparam int MEM_ACC_CONT_BANK_DATA_WIDTH = 64;
    localparam int MEM_ACC_CONT_BANK_ADDR_WIDTH = 12;
    localparam int MEM_ACC_CONT_BANK_DEPTH      = 4096;
    localparam int MEM_ACC_CONT_BANK_RD_LATENCY = 1;

    function automatic int bank_bytes(input int dw);
        return dw / 8;
    endfunction

    // One slot per in-flight stage plus one for the consumer-held head.
    function automatic int out_depth(input int lat);
        return lat + 1;
    endfunction

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_acc_cont_sram_bank_ofifo.sv
// Small synchronous FIFO buffering returned read beats (async low reset).
// Ports: clock_i, reset_n_i, push_i/push_data_i, pop_i, valid_o/data_o.
module mem_acc_cont_sram_bank_ofifo
    import mem_acc_cont_sram_bank_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full, do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = inc(rd_ptr_q);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/mem_acc_cont_sram_bank.sv
// Single SRAM bank: byte-enable writes, 1/2-cycle read pipeline, collision
// policy and credit-based read return buffer.
// Ports: clock, reset_n; wr_valid/wr_addr/wr_data/wr_byte_en;
// rd_req/rd_addr/rd_req_ready; rd_valid/rd_data/rd_collision/rd_ready.
module mem_acc_cont_sram_bank
    import mem_acc_cont_sram_bank_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_ACC_CONT_BANK_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ACC_CONT_BANK_ADDR_WIDTH,
    parameter int DEPTH      = MEM_ACC_CONT_BANK_DEPTH,
    parameter int RD_LATENCY = MEM_ACC_CONT_BANK_RD_LATENCY,
    parameter int BYPASS     = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    wr_valid,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_byte_en,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_req_ready,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_ready,
    output logic                    rd_collision
);

    localparam int BYTES     = bank_bytes(DATA_WIDTH);
    localparam int OUT_DEPTH = out_depth(RD_LATENCY);
    localparam int CW        = $clog2(OUT_DEPTH + 1);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [CW-1:0]       ODEP_C  = CW'(OUT_DEPTH);

    if (!(RD_LATENCY == 1 || RD_LATENCY == 2)) begin : g_bad_lat
        $fatal(1, "RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
        $fatal(1, "DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $fatal(1, "DEPTH exceeds address space");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_hit, rd_in_range, rd_fire, coll;
    logic [DATA_WIDTH-1:0] old_word, merged_word, stage_in;
    logic                  push_vld, push_coll;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  fifo_vld, pop;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [CW-1:0]         out_cnt_q, out_cnt_d;

    assign wr_hit       = wr_valid && ({1'b0, wr_addr} < DEPTH_C);
    assign rd_in_range  = ({1'b0, rd_addr} < DEPTH_C);
    // Credit check only; never looks at rd_ready.
    assign rd_req_ready = (out_cnt_q < ODEP_C);
    assign rd_fire      = rd_req && rd_req_ready;
    assign coll         = wr_hit && rd_in_range && (wr_addr == rd_addr);

    assign old_word = rd_in_range ? mem_q[rd_addr] : '0;

    always_comb begin
        merged_word = old_word;
        for (int b = 0; b < BYTES; b++) begin
            if (wr_byte_en[b]) merged_word[b*8 +: 8] = wr_data[b*8 +: 8];
        end
    end

    assign stage_in = (BYPASS != 0 && coll) ? merged_word : old_word;

    // Array has no reset; a write at a reset-asserted edge is dropped.
    always_ff @(posedge clock) begin
        if (reset_n && wr_hit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_byte_en[b]) mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    // The FIFO entry itself is the final pipeline register, so latency 1
    // pushes straight from the array at the accept edge.
    if (RD_LATENCY == 1) begin : g_lat1
        assign push_vld  = rd_fire;
        assign push_data = stage_in;
        assign push_coll = coll;
    end else begin : g_lat2
        logic                  st_vld_q;
        logic                  st_coll_q;
        logic [DATA_WIDTH-1:0] st_data_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                st_vld_q  <= 1'b0;
                st_coll_q <= 1'b0;
                st_data_q <= '0;
            end else begin
                st_vld_q <= rd_fire;
                if (rd_fire) begin
                    st_coll_q <= coll;
                    st_data_q <= stage_in;
                end
            end
        end

        assign push_vld  = st_vld_q;
        assign push_data = st_data_q;
        assign push_coll = st_coll_q;
    end

    mem_acc_cont_sram_bank_ofifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (OUT_DEPTH)
    ) u_ofifo (
        .clock_i     (clock),
        .reset_n_i   (reset_n),
        .push_i      (push_vld),
        .push_data_i ({push_coll, push_data}),
        .pop_i       (pop),
        .valid_o     (fifo_vld),
        .data_o      (fifo_head)
    );

    assign pop          = fifo_vld && rd_ready;
    assign rd_valid     = fifo_vld;
    assign rd_data      = fifo_vld ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign rd_collision = fifo_vld && fifo_head[DATA_WIDTH];

    always_comb begin
        out_cnt_d = out_cnt_q;
        unique case ({rd_fire, pop})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) out_cnt_q <= '0;
        else          out_cnt_q <= out_cnt_d;
    end

endmodule

// File: tb/tb_mem_acc_cont_sram_bank.sv
// Directed bench for two bank configurations:
// d0 = DEPTH 3000, latency 1, write-first; d1 = DEPTH 4096, latency 2, read-first.
module tb_mem_acc_cont_sram_bank;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [1:0]       wr_valid, rd_req, rd_ready;
    logic [1:0]       rd_req_ready, rd_valid, rd_collision;
    logic [1:0][11:0] wr_addr, rd_addr;
    logic [1:0][63:0] wr_data, rd_data;
    logic [1:0][7:0]  wr_byte_en;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mem_acc_cont_sram_bank #(
        .DATA_WIDTH(64), .ADDR_WIDTH(12), .DEPTH(3000),
        .RD_LATENCY(1), .BYPASS(1)
    ) u_d0 (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(wr_valid[0]), .wr_addr(wr_addr[0]),
        .wr_data(wr_data[0]), .wr_byte_en(wr_byte_en[0]),
        .rd_req(rd_req[0]), .rd_addr(rd_addr[0]),
        .rd_req_ready(rd_req_ready[0]), .rd_valid(rd_valid[0]),
        .rd_data(rd_data[0]), .rd_ready(rd_ready[0]),
        .rd_collision(rd_collision[0])
    );

    mem_acc_cont_sram_bank #(
        .DATA_WIDTH(64), .ADDR_WIDTH(12), .DEPTH(4096),
        .RD_LATENCY(2), .BYPASS(0)
    ) u_d1 (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(wr_valid[1]), .wr_addr(wr_addr[1]),
        .wr_data(wr_data[1]), .wr_byte_en(wr_byte_en[1]),
        .rd_req(rd_req[1]), .rd_addr(rd_addr[1]),
        .rd_req_ready(rd_req_ready[1]), .rd_valid(rd_valid[1]),
        .rd_data(rd_data[1]), .rd_ready(rd_ready[1]),
        .rd_collision(rd_collision[1])
    );

    function automatic logic [63:0] word(input int i);
        return 64'h0123_4567_0000_0000 | 64'(i);
    endfunction

    task automatic chk64(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write(input int d, input logic [11:0] a,
                         input logic [63:0] wd, input logic [7:0] be);
        wr_valid[d]   = 1'b1;
        wr_addr[d]    = a;
        wr_data[d]    = wd;
        wr_byte_en[d] = be;
        step();
        wr_valid[d] = 1'b0;
    endtask

    // One read (optionally with a same-cycle write) and its single beat.
    task automatic access(input int d, input logic [11:0] a, input logic do_wr,
                          input logic [63:0] wd, input logic [7:0] be,
                          input logic [63:0] ed, input logic ec,
                          input string tag);
        chk1({tag, "_rdy"}, rd_req_ready[d], 1'b1);
        rd_req[d]     = 1'b1;
        rd_addr[d]    = a;
        wr_valid[d]   = do_wr;
        wr_addr[d]    = a;
        wr_data[d]    = wd;
        wr_byte_en[d] = be;
        step();
        rd_req[d]   = 1'b0;
        wr_valid[d] = 1'b0;
        if (d == 1) step();
        chk1({tag, "_vld"}, rd_valid[d], 1'b1);
        chk64({tag, "_data"}, rd_data[d], ed);
        chk1({tag, "_coll"}, rd_collision[d], ec);
        step();
        chk1({tag, "_done"}, rd_valid[d], 1'b0);
    endtask

    task automatic thru(input int d, input int lat);
        for (int k = 0; k < 16 + lat; k++) begin
            if (k < 16) begin
                chk1("tp_rdy", rd_req_ready[d], 1'b1);
                rd_req[d]  = 1'b1;
                rd_addr[d] = 12'(k);
            end else begin
                rd_req[d] = 1'b0;
            end
            step();
            if (k >= lat - 1 && k <= 15 + lat - 1) begin
                chk1("tp_vld", rd_valid[d], 1'b1);
                chk64("tp_data", rd_data[d], word(k - lat + 1));
            end else begin
                chk1("tp_idle", rd_valid[d], 1'b0);
            end
        end
    endtask

    task automatic bp(input int d, input int depth);
        int acc = 0;
        rd_ready[d] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!rd_req_ready[d]) break;
            rd_req[d]  = 1'b1;
            rd_addr[d] = 12'(i);
            step();
            acc++;
        end
        rd_req[d] = 1'b0;
        chk64("bp_accepts", 64'(acc), 64'(depth));
        step();
        chk1("bp_vld", rd_valid[d], 1'b1);
        chk64("bp_head", rd_data[d], word(0));
        chk1("bp_full", rd_req_ready[d], 1'b0);
        step();
        chk64("bp_stable", rd_data[d], word(0));
        rd_ready[d] = 1'b1;
        step();
        chk1("bp_rdy_back", rd_req_ready[d], 1'b1);
        for (int j = 1; j < depth; j++) begin
            chk1("bp_rel_vld", rd_valid[d], 1'b1);
            chk64("bp_rel_data", rd_data[d], word(j));
            step();
        end
        chk1("bp_drained", rd_valid[d], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        wr_valid   = '0;
        rd_req     = '0;
        rd_ready   = 2'b11;
        wr_addr    = '0;
        rd_addr    = '0;
        wr_data    = '0;
        wr_byte_en = '0;
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            chk1("rst_rdy", rd_req_ready[d], 1'b1);
            chk1("rst_vld", rd_valid[d], 1'b0);
            chk64("rst_data", rd_data[d], 64'h0);
            chk1("rst_coll", rd_collision[d], 1'b0);
        end
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            wr_valid   = 2'b11;
            wr_addr    = {12'(i), 12'(i)};
            wr_data    = {word(i), word(i)};
            wr_byte_en = {8'hFF, 8'hFF};
            step();
        end
        wr_valid = '0;

        thru(0, 1);
        thru(1, 2);
        bp(0, 2);
        bp(1, 3);

        for (int d = 0; d < 2; d++) begin
            write(d, 12'd5, 64'h1122334455667788, 8'hFF);
            write(d, 12'd5, 64'h000000000000AAAA, 8'h03);
            access(d, 12'd5, 1'b0, '0, '0, 64'h112233445566AAAA, 1'b0, "be");
        end
        write(0, 12'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        access(0, 12'd5, 1'b0, '0, '0, 64'h112233445566AAAA, 1'b0, "be0");

        write(0, 12'd9, 64'h0, 8'hFF);
        write(1, 12'd9, 64'h0, 8'hFF);
        access(0, 12'd9, 1'b1, 64'hDEAD, 8'hFF, 64'hDEAD, 1'b1, "col_wf");
        access(1, 12'd9, 1'b1, 64'hDEAD, 8'hFF, 64'h0, 1'b1, "col_rf");
        access(0, 12'd9, 1'b0, '0, '0, 64'hDEAD, 1'b0, "col_wf_after");
        access(1, 12'd9, 1'b0, '0, '0, 64'hDEAD, 1'b0, "col_rf_after");
        access(0, 12'd9, 1'b1, 64'h1100, 8'h02, 64'h11AD, 1'b1, "col_merge");
        access(1, 12'd9, 1'b1, 64'h1100, 8'h02, 64'hDEAD, 1'b1, "col_old");
        access(1, 12'd9, 1'b0, '0, '0, 64'h11AD, 1'b0, "col_old_after");

        write(0, 12'd7, 64'h7777, 8'hFF);
        rd_req[1]  = 1'b1;
        rd_addr[1] = 12'd0;
        step();
        rd_addr[1] = 12'd1;
        step();
        rd_req[1] = 1'b0;
        chk1("rst_pre_vld", rd_valid[1], 1'b1);
        wr_valid[0]   = 1'b1;
        wr_addr[0]    = 12'd7;
        wr_data[0]    = 64'hBAD;
        wr_byte_en[0] = 8'hFF;
        #2 reset_n = 1'b0;
        #1;
        chk1("rst_mid_vld", rd_valid[1], 1'b0);
        chk64("rst_mid_data", rd_data[1], 64'h0);
        chk1("rst_mid_rdy", rd_req_ready[1], 1'b1);
        @(posedge clock);
        #2;
        reset_n     = 1'b1;
        wr_valid[0] = 1'b0;
        step();
        chk1("rst_post_vld0", rd_valid[1], 1'b0);
        step();
        chk1("rst_post_vld1", rd_valid[1], 1'b0);
        access(1, 12'd5, 1'b0, '0, '0, 64'h112233445566AAAA, 1'b0, "rst_keep");
        access(0, 12'd7, 1'b0, '0, '0, 64'h7777, 1'b0, "rst_nowr");

        write(0, 12'd2999, 64'h2999, 8'hFF);
        access(0, 12'd2999, 1'b0, '0, '0, 64'h2999, 1'b0, "last_addr");
        write(0, 12'd3500, 64'hFFFF, 8'hFF);
        access(0, 12'd3500, 1'b0, '0, '0, 64'h0, 1'b0, "oor_rd");
        access(0, 12'd3000, 1'b1, 64'hFFFF, 8'hFF, 64'h0, 1'b0, "oor_coll");
        access(0, 12'd2999, 1'b0, '0, '0, 64'h2999, 1'b0, "oor_keep");
        access(0, 12'd5, 1'b0, '0, '0, 64'h112233445566AAAA, 1'b0, "oor_keep5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
